// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async FIFO write port among NReq requesters.
// Grants whole bursts (up to MaxBurst beats or i_last) and never writes while i_full.
module fifo_wr_arbiter #(
   parameter int NReq     = 4,
   parameter int Width    = 8,
   parameter int MaxBurst = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NReq-1:0]               i_req,
   input  logic [NReq*Width-1:0]         i_data,
   input  logic [NReq-1:0]               i_last,
   input  logic                          i_full,
   output logic [NReq-1:0]               o_gnt,
   output logic                          o_wr_en,
   output logic [Width-1:0]              o_wr_data,
   output logic                          o_busy,
   output logic [$clog2(NReq)-1:0]       o_owner
);

   localparam int PW = $clog2(NReq);
   localparam int CW = $clog2(MaxBurst + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t          state_r, state_nxt_s;
   logic [PW-1:0]   rr_ptr_r, rr_ptr_nxt_s;
   logic [CW-1:0]   beat_cnt_r, beat_cnt_nxt_s;
   logic [PW-1:0]   owner_r, owner_nxt_s;
   logic [NReq-1:0] gnt_s;
   logic [Width-1:0] wr_data_s;
   logic            found_s;
   logic [PW-1:0]   win_s;
   int              scan_idx_s;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == PW'(NReq - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Round-robin winner: first requester at or after rr_ptr, wrapping below NReq.
   always_comb begin
      found_s    = 1'b0;
      win_s      = {PW{1'b0}};
      scan_idx_s = 0;
      for (int i = 0; i < NReq; i++) begin
         scan_idx_s = int'(rr_ptr_r) + i;
         scan_idx_s = (scan_idx_s >= NReq) ? (scan_idx_s - NReq) : scan_idx_s;
         if (!found_s && i_req[scan_idx_s]) begin
            found_s = 1'b1;
            win_s   = PW'(scan_idx_s);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and grant logic; reset low or FIFO full blocks every grant and holds state.
   always_comb begin
      gnt_s          = {NReq{1'b0}};
      state_nxt_s    = state_r;
      rr_ptr_nxt_s   = rr_ptr_r;
      beat_cnt_nxt_s = beat_cnt_r;
      owner_nxt_s    = owner_r;
      case (state_r)
         IDLE: begin
            if (rst_n && !i_full && found_s) begin
               gnt_s[win_s] = 1'b1;
               owner_nxt_s  = win_s;
               if (i_last[win_s] || (MaxBurst == 1)) begin
                  rr_ptr_nxt_s = next_ptr(win_s);
               end else begin
                  state_nxt_s    = BURST;
                  beat_cnt_nxt_s = CW'(1);
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         BURST: begin
            if (!rst_n || i_full) begin
               state_nxt_s = BURST;
            end else if (!i_req[owner_r]) begin
               // Owner dropped mid-burst: release without a grant this cycle.
               state_nxt_s    = IDLE;
               rr_ptr_nxt_s   = next_ptr(owner_r);
               beat_cnt_nxt_s = {CW{1'b0}};
            end else begin
               gnt_s[owner_r] = 1'b1;
               if (i_last[owner_r] || (beat_cnt_r == CW'(MaxBurst - 1))) begin
                  state_nxt_s    = IDLE;
                  rr_ptr_nxt_s   = next_ptr(owner_r);
                  beat_cnt_nxt_s = {CW{1'b0}};
               end else begin
                  beat_cnt_nxt_s = beat_cnt_r + CW'(1);
               end
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            beat_cnt_nxt_s = {CW{1'b0}};
         end
      endcase
   end

   // Write data mux: OR of one-hot selected slices, zero when nothing is granted.
   always_comb begin
      wr_data_s = {Width{1'b0}};
      for (int k = 0; k < NReq; k++) begin
         if (gnt_s[k]) begin
            wr_data_s = wr_data_s | i_data[k*Width +: Width];
         end else begin
            wr_data_s = wr_data_s;
         end
      end
   end

   // Arbiter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         rr_ptr_r   <= {PW{1'b0}};
         beat_cnt_r <= {CW{1'b0}};
         owner_r    <= {PW{1'b0}};
      end else begin
         state_r    <= state_nxt_s;
         rr_ptr_r   <= rr_ptr_nxt_s;
         beat_cnt_r <= beat_cnt_nxt_s;
         owner_r    <= owner_nxt_s;
      end
   end

   assign o_gnt     = gnt_s;
   assign o_wr_en   = |gnt_s;
   assign o_wr_data = wr_data_s;
   assign o_busy    = (state_r == BURST);
   assign o_owner   = owner_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NReq=4, Width=8, MaxBurst=4).
module tb_fifo_wr_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int MB   = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NREQ-1:0] i_req;
   logic [NREQ*W-1:0] i_data;
   logic [NREQ-1:0] i_last;
   logic            i_full;
   logic [NREQ-1:0] o_gnt;
   logic            o_wr_en;
   logic [W-1:0]    o_wr_data;
   logic            o_busy;
   logic [1:0]      o_owner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.NReq(NREQ), .Width(W), .MaxBurst(MB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (i_req),
      .i_data   (i_data),
      .i_last   (i_last),
      .i_full   (i_full),
      .o_gnt    (o_gnt),
      .o_wr_en  (o_wr_en),
      .o_wr_data(o_wr_data),
      .o_busy   (o_busy),
      .o_owner  (o_owner)
   );

   task automatic apply_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      i_req  = 4'b0000;
      i_last = 4'b0000;
      i_full = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      i_req  = 4'b1111;
      i_last = 4'b1111;
      i_full = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (o_gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", o_gnt); end
      checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", o_wr_en); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
      checks++; if (o_owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", o_owner); end
      @(negedge clk);
      rst_n = 1'b1;
      i_req = 4'b0000;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      logic [7:0] exp_data;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         i_req  = 4'b1111;
         i_last = 4'b1111;
         #1;
         exp_gnt  = 4'b0001 << (i % 4);
         exp_data = 8'hA0 + 8'(i % 4);
         checks++; if (o_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", i, o_gnt, exp_gnt); end
         checks++; if (o_wr_data !== exp_data) begin errors++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", i, o_wr_data, exp_data); end
         checks++; if (o_wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en cyc=%0d got=%b exp=1", i, o_wr_en); end
      end
      @(negedge clk);
      i_req = 4'b0000;
   endtask

   task automatic test_burst_cap();
      logic exp_busy;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         i_req  = 4'b0010;
         i_last = 4'b0000;
         #1;
         exp_busy = (i != 0);
         checks++; if (o_gnt !== 4'b0010) begin errors++; $display("FAIL cap_gnt beat=%0d got=%b exp=0010", i, o_gnt); end
         checks++; if (o_busy !== exp_busy) begin errors++; $display("FAIL cap_busy beat=%0d got=%b exp=%b", i, o_busy, exp_busy); end
         checks++; if (o_wr_data !== 8'hA1) begin errors++; $display("FAIL cap_data beat=%0d got=%h exp=a1", i, o_wr_data); end
      end
      @(negedge clk);
      i_req = 4'b0110;
      #1;
      checks++; if (o_gnt !== 4'b0100) begin errors++; $display("FAIL cap_next_gnt got=%b exp=0100", o_gnt); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL cap_next_busy got=%b exp=0", o_busy); end
      checks++; if (o_owner !== 2'd1) begin errors++; $display("FAIL cap_owner got=%0d exp=1", o_owner); end
      @(negedge clk);
      i_req = 4'b0000;
   endtask

   task automatic test_backpressure();
      int beats;
      logic full_pat;
      beats = 0;
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         full_pat = (i >= 2) && (i <= 4);
         i_req  = 4'b0010;
         i_last = 4'b0000;
         i_full = full_pat;
         #1;
         if (o_gnt[1]) beats++;
         if (full_pat) begin
            checks++; if (o_gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt cyc=%0d got=%b exp=0000", i, o_gnt); end
            checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL bp_wr_en cyc=%0d got=%b exp=0", i, o_wr_en); end
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL bp_busy cyc=%0d got=%b exp=1", i, o_busy); end
         end else begin
            checks++; if (o_gnt !== 4'b0010) begin errors++; $display("FAIL bp_beat cyc=%0d got=%b exp=0010", i, o_gnt); end
         end
      end
      checks++; if (beats !== 4) begin errors++; $display("FAIL bp_beats got=%0d exp=4", beats); end
      @(negedge clk);
      i_req = 4'b0000;
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bp_end_busy got=%b exp=0", o_busy); end
   endtask

   task automatic test_owner_drop();
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         i_req  = 4'b1001;
         i_last = 4'b0000;
         #1;
         checks++; if (o_gnt !== 4'b0001) begin errors++; $display("FAIL drop_lock cyc=%0d got=%b exp=0001", i, o_gnt); end
      end
      @(negedge clk);
      i_req = 4'b1000;
      #1;
      checks++; if (o_gnt !== 4'b0000) begin errors++; $display("FAIL drop_release_gnt got=%b exp=0000", o_gnt); end
      checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL drop_release_wr_en got=%b exp=0", o_wr_en); end
      @(negedge clk);
      #1;
      checks++; if (o_gnt !== 4'b1000) begin errors++; $display("FAIL drop_next_gnt got=%b exp=1000", o_gnt); end
      checks++; if (o_wr_data !== 8'hA3) begin errors++; $display("FAIL drop_next_data got=%h exp=a3", o_wr_data); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL drop_next_busy got=%b exp=0", o_busy); end
      @(negedge clk);
      #1;
      checks++; if (o_owner !== 2'd3) begin errors++; $display("FAIL drop_owner got=%0d exp=3", o_owner); end
      i_req = 4'b0000;
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         i_req  = 4'b0100;
         i_last = 4'b0000;
         #1;
      end
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ar_busy_before got=%b exp=1", o_busy); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b exp=0", o_busy); end
      checks++; if (o_gnt !== 4'b0000) begin errors++; $display("FAIL ar_gnt got=%b exp=0000", o_gnt); end
      checks++; if (o_owner !== 2'd0) begin errors++; $display("FAIL ar_owner got=%0d exp=0", o_owner); end
      @(negedge clk);
      rst_n  = 1'b1;
      i_req  = 4'b1111;
      i_last = 4'b1111;
      #1;
      checks++; if (o_gnt !== 4'b0001) begin errors++; $display("FAIL ar_first_gnt got=%b exp=0001", o_gnt); end
      @(negedge clk);
      #1;
      checks++; if (o_gnt !== 4'b0010) begin errors++; $display("FAIL ar_second_gnt got=%b exp=0010", o_gnt); end
      i_req = 4'b0000;
   endtask

   initial begin
      for (int k = 0; k < NREQ; k++) begin
         i_data[k*W +: W] = 8'hA0 + 8'(k);
      end
      i_full = 1'b0;
      test_reset();
      test_round_robin();
      test_burst_cap();
      test_backpressure();
      test_owner_drop();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
